// File: rtl/add_row_stream.sv
// Streaming element-wise adder for packed matrix rows, with per-element and
// sticky per-matrix overflow reporting and a one-deep registered output stage.
module add_row_stream #(
    parameter int N_ELEM = 5,
    parameter int EW     = 8,
    parameter int N_ROWS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_ELEM*EW-1:0]   a_row,
    input  logic [N_ELEM*EW-1:0]   b_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_ELEM*EW-1:0]   s_row,
    output logic [N_ELEM-1:0]      ovf_row,
    output logic                   ovf,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = N_ELEM * EW;
    localparam int CW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   row_cnt;
    logic [W-1:0]    sum_word;
    logic [N_ELEM-1:0] ovf_vec;
    logic            slot_free;
    logic            last_row;
    logic            xfer;
    logic            consume;

    // Each field gets its own EW+1 bit signed sum; no carry crosses fields.
    for (genvar g = 0; g < N_ELEM; g++) begin : g_elem
        logic [EW:0] ext_sum;
        assign ext_sum = {a_row[g*EW+EW-1], a_row[g*EW +: EW]}
                       + {b_row[g*EW+EW-1], b_row[g*EW +: EW]};
        assign sum_word[g*EW +: EW] = ext_sum[EW-1:0];
        assign ovf_vec[g]           = ext_sum[EW] ^ ext_sum[EW-1];
    end

    assign slot_free = !out_valid || out_ready;
    assign last_row  = (row_cnt == CW'(N_ROWS - 1));
    assign xfer      = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                in_ready = slot_free;
                if (in_valid && slot_free && last_row) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (consume) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row counter saturates on the final row; the FSM leaves LOAD on that transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt <= '0;
            ovf     <= 1'b0;
        end else if (state == IDLE && start) begin
            row_cnt <= '0;
            ovf     <= 1'b0;
        end else if (xfer) begin
            row_cnt <= last_row ? row_cnt : row_cnt + CW'(1);
            ovf     <= ovf | (|ovf_vec);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_row     <= '0;
            ovf_row   <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            s_row     <= sum_word;
            ovf_row   <= ovf_vec;
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_row_stream.sv
// Bench for add_row_stream: a fixed vector table, backpressure, reset and
// randomized matrices, all checked against an arithmetic reference model.
module tb_add_row_stream;

    localparam int N_ELEM = 5;
    localparam int EW     = 8;
    localparam int N_ROWS = 5;
    localparam int W      = N_ELEM * EW;

    typedef struct {
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic [W-1:0]      s;
        logic [N_ELEM-1:0] o;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      a_row;
    logic [W-1:0]      b_row;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      s_row;
    logic [N_ELEM-1:0] ovf_row;
    logic              ovf;
    logic              busy;
    logic              done;

    int tests  = 0;
    int failed = 0;

    vec_t              table_v[N_ROWS];
    logic [W-1:0]      row_a[N_ROWS];
    logic [W-1:0]      row_b[N_ROWS];
    logic [W-1:0]      exp_s[N_ROWS];
    logic [N_ELEM-1:0] exp_o[N_ROWS];

    add_row_stream #(.N_ELEM(N_ELEM), .EW(EW), .N_ROWS(N_ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a_row(a_row), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .s_row(s_row),
        .ovf_row(ovf_row), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: signed integer addition, wrapped to EW bits, overflow when out of range.
    function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] s, output logic [N_ELEM-1:0] o);
        s = '0;
        o = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            int sa;
            int sb;
            int sum;
            sa  = int'($signed(a[i*EW +: EW]));
            sb  = int'($signed(b[i*EW +: EW]));
            sum = sa + sb;
            s[i*EW +: EW] = sum[EW-1:0];
            o[i] = (sum > (1 << (EW-1)) - 1) || (sum < -(1 << (EW-1)));
        end
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, W'(actual), W'(expected));
    endtask

    task automatic applyStimulus(input logic st, input logic iv, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ordy);
        start     = st;
        in_valid  = iv;
        a_row     = a;
        b_row     = b;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] randRow();
        logic [63:0] tmp;
        tmp = {$urandom(), $urandom()};
        return tmp[W-1:0];
    endfunction

    task automatic fillRandom;
        for (int r = 0; r < N_ROWS; r++) begin
            row_a[r] = randRow();
            row_b[r] = randRow();
            refModel(row_a[r], row_b[r], exp_s[r], exp_o[r]);
        end
    endtask

    // One full matrix: expected handshake, data and flags derived from row/consume counts.
    task automatic runMatrix(input bit rand_flow, input bit poke_start, input int stall);
        int          sent;
        int          consumed;
        bit          sticky;
        bit          exp_done;
        bit          done_seen;
        logic        iv;
        logic        ordy;
        logic        st;
        logic        exp_ir;
        logic [W-1:0] a;
        logic [W-1:0] b;
        sent      = 0;
        consumed  = 0;
        sticky    = 1'b0;
        exp_done  = 1'b0;
        done_seen = 1'b0;
        applyStimulus(1'b1, 1'b1, row_a[0], row_b[0], 1'b1);
        checkBit("start_cycle_in_ready", in_ready, 1'b0);
        checkBit("idle_busy", busy, 1'b0);
        tick();
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            iv   = rand_flow ? ($urandom_range(3) != 0) : 1'b1;
            ordy = (cyc < stall) ? 1'b0 : (rand_flow ? ($urandom_range(2) != 0) : 1'b1);
            st   = (poke_start && sent < N_ROWS) ? ($urandom_range(1) == 1) : 1'b0;
            if (sent < N_ROWS) begin
                a = row_a[sent];
                b = row_b[sent];
            end else begin
                a = randRow();
                b = randRow();
            end
            applyStimulus(st, iv, a, b, ordy);
            exp_ir = (sent < N_ROWS) && (sent == consumed || ordy);
            checkBit("in_ready", in_ready, exp_ir);
            checkBit("out_valid", out_valid, sent != consumed);
            checkBit("ovf_sticky", ovf, sticky);
            checkBit("done", done, exp_done);
            checkBit("busy", busy, !exp_done);
            done_seen = exp_done;
            exp_done  = 1'b0;
            if (sent != consumed) begin
                checkOutput("s_row", s_row, exp_s[consumed]);
                checkOutput("ovf_row", W'(ovf_row), W'(exp_o[consumed]));
                if (ordy) begin
                    consumed++;
                    exp_done = (consumed == N_ROWS);
                end
            end
            if (iv && exp_ir) begin
                sticky = sticky | (|exp_o[sent]);
                sent++;
            end
            tick();
        end
        if (!done_seen) begin
            tests++;
            failed++;
            $display("[TB] FAIL matrix_timeout: sent %0d consumed %0d, expected done pulse", sent, consumed);
        end
        applyStimulus(1'b0, 1'b1, randRow(), randRow(), 1'b1);
        checkBit("after_busy", busy, 1'b0);
        checkBit("after_done", done, 1'b0);
        checkBit("after_out_valid", out_valid, 1'b0);
        checkBit("after_in_ready", in_ready, 1'b0);
        checkBit("after_ovf_hold", ovf, sticky);
        tick();
    endtask

    // Reset asserted after two accepted rows must clear everything immediately.
    task automatic resetMidMatrix;
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, table_v[i].a, table_v[i].b, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkBit("pre_reset_ovf", ovf, 1'b1);
        checkBit("pre_reset_out_valid", out_valid, 1'b1);
        rst = 1'b0;
        #1;
        checkBit("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_s_row", s_row, '0);
        checkOutput("rst_ovf_row", W'(ovf_row), '0);
        checkBit("rst_ovf", ovf, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_in_ready", in_ready, 1'b0);
        checkBit("rst_done", done, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkBit("rst_hold_done", done, 1'b0);
        end
        rst = 1'b1;
        tick();
        checkBit("post_rst_done", done, 1'b0);
        checkBit("post_rst_busy", busy, 1'b0);
    endtask

    initial begin
        // Vector table: {a, b, expected sum, expected overflow}, element 0 in the LSBs.
        table_v[0] = '{a: 40'h05_04_03_02_01, b: 40'hFB_28_1E_14_0A, s: 40'h00_2C_21_16_0B, o: 5'b00000};
        table_v[1] = '{a: 40'h00_FF_64_80_7F, b: 40'h00_01_1B_FF_01, s: 40'h00_00_7F_7F_80, o: 5'b00011};
        table_v[2] = '{a: 40'h80_80_80_80_80, b: 40'h80_80_80_80_80, s: 40'h00_00_00_00_00, o: 5'b11111};
        table_v[3] = '{a: 40'h7F_7F_7F_7F_7F, b: 40'h7F_7F_7F_7F_7F, s: 40'hFE_FE_FE_FE_FE, o: 5'b11111};
        table_v[4] = '{a: 40'h00_64_9C_32_CE, b: 40'hFF_1B_E4_4E_B2, s: 40'hFF_7F_80_80_80, o: 5'b00010};

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        #12;
        checkBit("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_s_row", s_row, '0);
        checkOutput("reset_ovf_row", W'(ovf_row), '0);
        checkBit("reset_ovf", ovf, 1'b0);
        checkBit("reset_busy", busy, 1'b0);
        checkBit("reset_in_ready", in_ready, 1'b0);
        checkBit("reset_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        for (int r = 0; r < N_ROWS; r++) begin
            row_a[r] = table_v[r].a;
            row_b[r] = table_v[r].b;
            exp_s[r] = table_v[r].s;
            exp_o[r] = table_v[r].o;
        end
        runMatrix(1'b0, 1'b0, 0);

        fillRandom();
        runMatrix(1'b0, 1'b0, 4);

        fillRandom();
        runMatrix(1'b1, 1'b1, 0);

        resetMidMatrix();
        fillRandom();
        runMatrix(1'b0, 1'b0, 0);

        for (int m = 0; m < 20; m++) begin
            fillRandom();
            runMatrix(1'b1, (m % 2) == 1, (m % 3 == 0) ? 2 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
